div_16x8_seq: RTL

DIV_16X8_SEQ -- requirements
Module: div_16x8_seq

---
 rtl/div_16x8_seq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/div_16x8_seq.sv
// Sequential 16/8 unsigned restoring divider with valid/ready handshakes on both sides.
// Optional round-to-nearest quotient when DIV_ROUND_EN is defined.
module div_16x8_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] R,
  input  logic [7:0]  B,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  Q,
  output logic [7:0]  REM,
  output logic        ovf,
  output logic        div0,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never depends on ready, and the result holds until it is taken.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
`ifdef DIV_ROUND_EN
    S_ROUND = 2'd2,
`endif
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  rem_q, rem_d;
  logic [7:0]  dvd_q, dvd_d;
  logic [7:0]  q_q, q_d;
  logic [7:0]  b_q, b_d;
  logic        ovf_q, ovf_d;
  logic        div0_q, div0_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready_q, in_ready_d;
  logic [8:0]  trial;
  logic [8:0]  diff;

  // The partial remainder is always < B, so the 9-bit trial is < 2B and the
  // difference always fits back into 8 bits.
  assign trial = {rem_q, dvd_q[7]};
  assign diff  = trial - {1'b0, b_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    q_d         = q_q;
    b_d         = b_q;
    ovf_d       = ovf_q;
    div0_d      = div0_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          b_d   = B;
          cnt_d = 3'd0;
          if (B == 8'd0) begin
            div0_d = 1'b1; ovf_d = 1'b0; q_d = 8'hFF; rem_d = 8'h00;
            out_valid_d = 1'b1;
            state_d = S_DONE;
          end else if (R[15:8] >= B) begin
            div0_d = 1'b0; ovf_d = 1'b1; q_d = 8'hFF; rem_d = 8'h00;
            out_valid_d = 1'b1;
            state_d = S_DONE;
          end else begin
            // High byte is already a valid partial remainder; only 8 steps remain.
            div0_d = 1'b0; ovf_d = 1'b0; q_d = 8'h00;
            rem_d  = R[15:8];
            dvd_d  = R[7:0];
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        dvd_d = {dvd_q[6:0], 1'b0};
        if (trial >= {1'b0, b_q}) begin
          rem_d = diff[7:0];
          q_d   = {q_q[6:0], 1'b1};
        end else begin
          rem_d = trial[7:0];
          q_d   = {q_q[6:0], 1'b0};
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
`ifdef DIV_ROUND_EN
          state_d = S_ROUND;
`else
          state_d     = S_DONE;
          out_valid_d = 1'b1;
`endif
        end
      end
`ifdef DIV_ROUND_EN
      S_ROUND: begin
        if (({rem_q, 1'b0} >= {1'b0, b_q}) && (q_q != 8'hFF)) q_d = q_q + 8'd1;
        state_d     = S_DONE;
        out_valid_d = 1'b1;
      end
`endif
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      rem_q       <= 8'd0;
      dvd_q       <= 8'd0;
      q_q         <= 8'd0;
      b_q         <= 8'd0;
      ovf_q       <= 1'b0;
      div0_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      q_q         <= q_d;
      b_q         <= b_d;
      ovf_q       <= ovf_d;
      div0_q      <= div0_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign Q         = q_q;
  assign REM       = rem_q;
  assign ovf       = ovf_q;
  assign div0      = div0_q;
  assign out_valid = out_valid_q;
  assign dbg_state = state_q;

endmodule
